lcd_cmd_sched: RTL
==================

// Module: lcd_cmd_sched
// PURPOSE
//  Command scheduler in front of lcd_ctrl. Two requesters push 3-bit LCD commands.
//  A round-robin arbiter accepts at most one command per cycle into a command FIFO.
//  An issue FSM drains the FIFO into lcd_ctrl, obeying busy. For a load command (3'd0)
//  it also streams the image bytes from an external image memory to lcd_ctrl datain.
// PARAMETERS
//  FIFO_DEPTH  4    command FIFO entries (power of 2, >=2)
//  IMG_N       108  bytes streamed per load command
//  AW          7    image memory address width (2**AW >= IMG_N)
// PORTS
//  clk          in   1   clock, all logic on posedge
//  reset        in   1   synchronous, active-high reset
//  req0 / req1  in   1   requester 0 / 1 command request (level, held until granted)
//  rcmd0/rcmd1  in   3   command of requester 0 / 1
//  gnt0 / gnt1  out  1   1-cycle pulse: the command was pushed into the FIFO this cycle
//  cmd          out  3   to lcd_ctrl cmd
//  cmd_valid    out  1   to lcd_ctrl cmd_valid
//  datain       out  8   to lcd_ctrl datain (= img_data while streaming, else 8'h00)
//  busy         in   1   from lcd_ctrl busy
//  img_rd       out  1   image memory read strobe
//  img_addr     out  AW  image memory address
//  img_data     in   8   image memory data, valid the cycle after img_rd
//  fifo_cnt     out  $clog2(FIFO_DEPTH)+1   current FIFO occupancy
//  sched_idle   out  1   FIFO empty and FSM in IDLE
// BEHAVIOUR
//  Reset: all outputs 0 (sched_idle=1); FIFO emptied; RR pointer -> requester 0.
//  Reset mid-load aborts the stream at once; no further img_rd or cmd_valid.
//  Arbiter:
//   - grant only when FIFO not full (fifo_cnt<FIFO_DEPTH), or when full with a pop in
//     the same cycle.
//   - both req high: grant the one not granted last; winner becomes last-granted.
//   - loser keeps req high and is granted the next cycle, FIFO space permitting.
//   - push and pop in the same cycle: fifo_cnt unchanged.
//   - full and no pop: gnt0=gnt1=0.
//  Issue FSM, states IDLE, ISSUE, LOAD, GAP:
//   - IDLE: FIFO non-empty and busy=0 -> ISSUE. This check is combinational in IDLE;
//     the ISSUE actions happen in that same cycle t.
//   - ISSUE (1 cycle, t): cmd_valid=1, cmd=FIFO head, pop.
//     - head==0: also img_rd=1, img_addr=0 -> LOAD.
//     - otherwise -> GAP.
//   - LOAD: cycles t+1..t+IMG_N-1 drive img_rd=1 with img_addr=1..IMG_N-1.
//     datain=img_data during cycles t+1..t+IMG_N, so byte k is on datain in cycle t+k+1.
//     After cycle t+IMG_N -> GAP.
//   - GAP (1 cycle): ignores busy, covering lcd_ctrl's registered busy -> IDLE.
//   - cmd_valid is never asserted on back-to-back cycles.
//   - cmd and datain are 0 whenever not driven.
//  Latency: from a cycle with a push into an empty FIFO, with busy=0, cmd_valid
//   rises the next cycle.
//  Command codes other than 3'd0 are forwarded opaquely; no code is rejected.
// CONFIGURATION
//  SCHED_FIXED_PRI_EN defined:
//   - requester 0 always wins when both request; RR pointer logic is removed.
//   - requester 1 may starve.
//  SCHED_FIXED_PRI_EN undefined (default): round-robin as above.
// TESTING
//  1. Reset, req0=1 with rcmd0=0, busy=0
//     -> gnt0 at cycle 1; cmd_valid/cmd=0 at cycle 2.
//     -> img_addr 0..107 on cycles 2..109; datain=img_data on cycles 3..110.
//     -> one GAP cycle, then sched_idle=1.
//  2. req0 and req1 high continuously (rcmd0=3, rcmd1=4), busy=0
//     -> grants alternate 0,1,0,1.
//     -> issued cmd sequence 3,4,3,4 with cmd_valid spaced >=2 cycles.
//  3. busy held 1, 5 pushes with FIFO_DEPTH=4
//     -> 4 grants then no grant, fifo_cnt=4.
//     -> release busy: first pop grants the 5th in the same cycle, fifo_cnt stays 4.
//  4. busy=1 for 20 cycles after a command is issued
//     -> no cmd_valid until the cycle after busy falls.
//  5. Assert reset at img_addr=50 of a load
//     -> next cycle img_rd=0, cmd_valid=0, fifo_cnt=0, sched_idle=1.
//     -> a new load then starts at img_addr=0.
//  6. SCHED_FIXED_PRI_EN defined, both requesting continuously
//     -> only gnt0 pulses; gnt1 only after req0 drops.

Source files
------------

// File: rtl/lcd_cmd_sched.sv
// lcd_cmd_sched: round-robin command scheduler feeding lcd_ctrl.
// Two requesters push 3-bit commands into a small FIFO; an issue FSM drains
// the FIFO into lcd_ctrl, honouring busy, and streams IMG_N image bytes
// from external memory for every load command (code 3'd0).
// Optional build macro: SCHED_FIXED_PRI_EN -- requester 0 always wins ties
// and the round-robin pointer is removed (requester 1 may starve).
// Outputs suffixed _c are combinational; o_fifo_cnt and o_sched_idle are registered.
module lcd_cmd_sched #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IMG_N      = 108,
  parameter int unsigned AW         = 7
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_req0,
  input  logic                          i_req1,
  input  logic [2:0]                    i_rcmd0,
  input  logic [2:0]                    i_rcmd1,
  output logic                          o_gnt0_c,
  output logic                          o_gnt1_c,
  output logic [2:0]                    o_cmd_c,
  output logic                          o_cmd_valid_c,
  output logic [7:0]                    o_datain_c,
  input  logic                          i_busy,
  output logic                          o_img_rd_c,
  output logic [AW-1:0]                 o_img_addr_c,
  input  logic [7:0]                    i_img_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
  output logic                          o_sched_idle
);

  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned AWC = AW + 1;
  localparam logic [CW-1:0]  FIFO_FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [AWC-1:0] IMG_END       = AWC'(IMG_N);
  localparam logic [2:0]     CMD_LOAD      = 3'd0;

  // ISSUE is never held in the state register: it is the effective state of
  // an IDLE cycle in which a command can go out, so issue costs no extra cycle.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_LOAD  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_eff;
  state_t          w_state_nxt;

  logic [2:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [AWC-1:0]  r_addr;
  logic [AWC-1:0]  w_addr_nxt;
  logic            r_sched_idle;

  logic            w_empty;
  logic            w_full;
  logic [2:0]      w_head;
  logic            w_pick1;
  logic            w_push;
  logic [2:0]      w_push_cmd;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_pop;
  logic            w_cmd_valid;
  logic [2:0]      w_cmd;
  logic            w_img_rd;
  logic [AW-1:0]   w_img_addr;
  logic [7:0]      w_datain;

`ifndef SCHED_FIXED_PRI_EN
  logic            r_last;
`endif

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == FIFO_FULL_CNT);
  assign w_head  = r_mem[r_rd_ptr];

  // Arbiter: choose a requester and push when there is room (or a pop frees it).
  always_comb begin
    w_pick1    = 1'b0;
`ifdef SCHED_FIXED_PRI_EN
    w_pick1    = i_req1 && !i_req0;
`else
    if (i_req0 && i_req1) begin
      w_pick1  = !r_last;
    end else begin
      w_pick1  = i_req1;
    end
`endif
    w_push     = !i_reset && (!w_full || w_pop) && (i_req0 || i_req1);
    w_gnt0     = w_push && !w_pick1;
    w_gnt1     = w_push && w_pick1;
    w_push_cmd = w_pick1 ? i_rcmd1 : i_rcmd0;
  end

`ifndef SCHED_FIXED_PRI_EN
  // Round-robin pointer: remembers the last granted requester; starts favouring 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last <= 1'b1;
    end else if (w_push) begin
      r_last <= w_pick1;
    end
  end
`endif

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_cmd;
    end
  end

  // FIFO occupancy next value; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else if (!w_push && w_pop) begin
      w_cnt_nxt = r_cnt - CW'(1);
    end
  end

  // FIFO pointers and count; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_cnt <= w_cnt_nxt;
    end
  end

  // Issue FSM: next state and all lcd_ctrl / image-memory drive.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_pop       = 1'b0;
    w_cmd_valid = 1'b0;
    w_cmd       = 3'd0;
    w_img_rd    = 1'b0;
    w_img_addr  = '0;
    w_datain    = 8'h00;
    w_state_eff = r_state;
    if ((r_state == S_IDLE) && !w_empty && !i_busy) begin
      w_state_eff = S_ISSUE;
    end
    case (w_state_eff)
      S_IDLE: begin
        w_addr_nxt = '0;
      end
      S_ISSUE: begin
        w_cmd_valid = 1'b1;
        w_cmd       = w_head;
        w_pop       = 1'b1;
        if (w_head == CMD_LOAD) begin
          w_img_rd    = 1'b1;
          w_img_addr  = '0;
          w_addr_nxt  = AWC'(1);
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_GAP;
        end
      end
      S_LOAD: begin
        // Data lags the read by one cycle, so datain runs one cycle past the last read.
        w_datain = i_img_data;
        if (r_addr < IMG_END) begin
          w_img_rd   = 1'b1;
          w_img_addr = r_addr[AW-1:0];
          w_addr_nxt = r_addr + AWC'(1);
        end else begin
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        // One dead cycle lets lcd_ctrl's registered busy catch up.
        w_addr_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (i_reset) begin
      w_pop       = 1'b0;
      w_cmd_valid = 1'b0;
      w_cmd       = 3'd0;
      w_img_rd    = 1'b0;
      w_img_addr  = '0;
      w_datain    = 8'h00;
    end
  end

  // FSM state and stream address registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  // Idle flag registered from the next-state view of FIFO and FSM.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sched_idle <= 1'b1;
    end else begin
      r_sched_idle <= (w_cnt_nxt == '0) && (w_state_nxt == S_IDLE);
    end
  end

  assign o_gnt0_c      = w_gnt0;
  assign o_gnt1_c      = w_gnt1;
  assign o_cmd_c       = w_cmd;
  assign o_cmd_valid_c = w_cmd_valid;
  assign o_datain_c    = w_datain;
  assign o_img_rd_c    = w_img_rd;
  assign o_img_addr_c  = w_img_addr;
  assign o_fifo_cnt    = r_cnt;
  assign o_sched_idle  = r_sched_idle;

endmodule
